// File: rtl/zbus_fifo_sync.sv
`default_nettype none
// ============================================================================
//  Module   : zbus_fifo_sync
//  Purpose  : Single-clock zbus FIFO. Width is parametrised and the depth may
//             be any value, including non-powers of two. It provides a
//             synchronous flush, almost-full and almost-empty flags, and an
//             optional full pass-through mode.
//  Revision : 1.0  initial release
// ============================================================================
module zbus_fifo_sync #(
    parameter int BW  = 8,
    parameter int LN  = 4,
    parameter int LNL = (LN > 1) ? $clog2(LN) : 1,
    parameter int CNL = $clog2(LN + 1),
    parameter int FPS = 0,
    parameter int AFL = LN - 1,
    parameter int AEM = 1
) (
    input  logic           z_clk,
    input  logic           z_rst,
    input  logic           z_clr,
    input  logic           zi_vld,
    input  logic [BW-1:0]  zi_bus,
    output logic           zi_ack,
    output logic [CNL-1:0] zi_num,
    output logic           zi_afl,
    output logic           zo_vld,
    output logic [BW-1:0]  zo_bus,
    input  logic           zo_ack,
    output logic [CNL-1:0] zo_num,
    output logic           zo_aem
);

    localparam logic [CNL-1:0] c_LN       = CNL'(LN);
    localparam logic [LNL-1:0] c_PTR_LAST = LNL'(LN - 1);

    logic [LNL-1:0] wpb_q, wpb_d;
    logic [LNL-1:0] rpb_q, rpb_d;
    logic [CNL-1:0] cnt_q, cnt_d;
    logic [BW-1:0]  mem [LN];

    logic w_zi_ack;
    logic w_zo_vld;
    logic w_zi_trn;
    logic w_zo_trn;

    // Pointers step through 0..LN-1 and wrap explicitly, so any depth works.
    function automatic logic [LNL-1:0] ptr_inc(input logic [LNL-1:0] p);
        return (p == c_PTR_LAST) ? '0 : p + LNL'(1);
    endfunction

    // Write acknowledge: pass-through mode lets a completing read free the slot.
    generate
        if (FPS != 0) begin : g_fps_on
            assign w_zi_ack = ((cnt_q != c_LN) | zo_ack) & ~z_clr;
        end else begin : g_fps_off
            assign w_zi_ack = (cnt_q != c_LN) & ~z_clr;
        end
    endgenerate

    assign w_zo_vld = (cnt_q != '0) & ~z_clr;
    assign w_zi_trn = zi_vld & w_zi_ack;
    assign w_zo_trn = w_zo_vld & zo_ack;

    assign zi_ack = w_zi_ack;
    assign zo_vld = w_zo_vld;
    assign zi_num = c_LN - cnt_q;
    assign zo_num = cnt_q;
    assign zi_afl = (32'(cnt_q) >= AFL);
    assign zo_aem = (32'(cnt_q) <= AEM);
    assign zo_bus = mem[rpb_q];

    // Next-state for pointers and occupancy; flush overrides any transfer.
    always_comb begin
        wpb_d = wpb_q;
        rpb_d = rpb_q;
        cnt_d = cnt_q;
        if (z_clr) begin
            wpb_d = '0;
            rpb_d = '0;
            cnt_d = '0;
        end else begin
            if (w_zi_trn) wpb_d = ptr_inc(wpb_q);
            if (w_zo_trn) rpb_d = ptr_inc(rpb_q);
            case ({w_zi_trn, w_zo_trn})
                2'b10:   cnt_d = cnt_q + CNL'(1);
                2'b01:   cnt_d = cnt_q - CNL'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Pointer and occupancy registers with asynchronous reset.
    always_ff @(posedge z_clk or posedge z_rst) begin
        if (z_rst) begin
            wpb_q <= '0;
            rpb_q <= '0;
            cnt_q <= '0;
        end else begin
            wpb_q <= wpb_d;
            rpb_q <= rpb_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage array; contents survive reset and flush.
    always_ff @(posedge z_clk) begin
        if (w_zi_trn) mem[wpb_q] <= zi_bus;
    end

endmodule
`default_nettype wire
